// File: rtl/bitwise_logic_unit.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshaking on both
// sides, an optional accumulator that can stand in for operand A, and registered
// result flags (zero, parity, population count).
//
// Stage 1 captures the request. Stage 2 captures the computed result and flags.
// The accumulator is written when an accumulator-mode entry moves from stage 1
// to stage 2. Because of that, consecutive accumulator operations chain with no
// bubble between them.
module bitwise_logic_unit #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CW-1:0]    out_popcnt,
    output logic [WIDTH-1:0] acc_value
);

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NOT_A  = 3'd3,
        OP_NAND   = 3'd4,
        OP_NOR    = 3'd5,
        OP_XNOR   = 3'd6,
        OP_PASS_B = 3'd7
    } op_e;

    // One result bit for a given opcode; every operation is purely bitwise.
    function automatic logic bit_op(input op_e op, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_NOT_A:  r = ~a;
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            OP_XNOR:   r = ~(a ^ b);
            OP_PASS_B: r = b;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    op_e              s1_op_q,    s1_op_d;
    logic             s1_acc_q,   s1_acc_d;

    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic             out_zero_q,   out_zero_d;
    logic             out_parity_q, out_parity_d;
    logic [CW-1:0]    out_popcnt_q, out_popcnt_d;

    logic [WIDTH-1:0] acc_q, acc_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic e2;       // stage 2 can take a new entry this cycle
    logic e1;       // stage 1 can take a new entry this cycle
    logic in_xfer;  // request accepted on the coming edge
    logic s1_xfer;  // stage 1 entry moves to stage 2 on the coming edge

    // Stage 2 frees up when it is empty or draining. Stage 1 frees up when it
    // is empty or about to move forward.
    assign e2      = !out_valid_q || out_ready;
    assign e1      = !s1_valid_q || e2;
    assign in_ready = e1;
    assign in_xfer = in_valid && e1;
    assign s1_xfer = s1_valid_q && e2;

    // ------------------------------------------------------------------
    // Datapath: the result is computed from stage 1 contents
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] res_c;
    logic             zero_c;
    logic             parity_c;
    logic [CW-1:0]    popcnt_c;

    // When in accumulator mode, the accumulator stands in for operand A.
    assign a_eff = s1_acc_q ? acc_q : s1_a_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign res_c[gi] = bit_op(s1_op_q, a_eff[gi], s1_b_q[gi]);
    end

    assign zero_c   = (res_c == '0);
    assign parity_c = ^res_c;

    // Count the ones in the result. WIDTH is at most 64, so a linear sum is
    // enough here.
    always_comb begin
        popcnt_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            popcnt_c = popcnt_c + CW'(res_c[i]);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Stage 1 loads a new request whenever it can accept one. If it moves
    // forward and no request is waiting, it empties.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_acc_d   = s1_acc_q;
        if (e1) begin
            s1_valid_d = in_valid;
        end
        if (in_xfer) begin
            s1_a_d   = in_a;
            s1_b_d   = in_b;
            s1_op_d  = op_e'(in_op);
            s1_acc_d = in_acc;
        end
    end

    // Stage 2 captures the result and its flags together. It holds everything
    // while the output is stalled.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_zero_d   = out_zero_q;
        out_parity_d = out_parity_q;
        out_popcnt_d = out_popcnt_q;
        if (e2) begin
            out_valid_d = s1_valid_q;
        end
        if (s1_xfer) begin
            out_result_d = res_c;
            out_zero_d   = zero_c;
            out_parity_d = parity_c;
            out_popcnt_d = popcnt_c;
        end
    end

    // The accumulator takes write-back from accumulator-mode entries.
    // A clear overrides the write-back. The operation that is moving forward
    // in the same cycle has already used the pre-clear value through a_eff.
    always_comb begin
        acc_d = acc_q;
        if (s1_xfer && s1_acc_q) begin
            acc_d = res_c;
        end
        if (acc_clr) begin
            acc_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Stage 1 register. Reset empties it, discarding any pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_AND;
            s1_acc_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s1_acc_q   <= s1_acc_d;
        end
    end

    // Stage 2 register. Reset shows an all-zero result with the zero flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_zero_q   <= 1'b1;
            out_parity_q <= 1'b0;
            out_popcnt_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_zero_q   <= out_zero_d;
            out_parity_q <= out_parity_d;
            out_popcnt_q <= out_popcnt_d;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_zero   = out_zero_q;
    assign out_parity = out_parity_q;
    assign out_popcnt = out_popcnt_q;
    assign acc_value  = acc_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Bench for bitwise_logic_unit. Three instances (WIDTH 4, 1, 64) are each
// compared every cycle against a transaction-queue reference model. Directed
// sequences on the 4-bit instance pin literal expected values, and randomized
// traffic exercises all three widths.
module tb_bitwise_logic_unit;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [2:0]  op;
        logic        acc;
        logic        vis;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid_s [3];
    logic        in_acc_s   [3];
    logic        acc_clr_s  [3];
    logic        out_ready_s[3];
    logic [2:0]  op_s       [3];
    logic [63:0] a_s        [3];
    logic [63:0] b_s        [3];

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] coll_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bitwise operation semantics written directly from the opcode table.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input logic [63:0] mask);
        logic [63:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~a;
            3'd4:    r = ~(a & b);
            3'd5:    r = ~(a | b);
            3'd6:    r = ~(a ^ b);
            default: r = b;
        endcase
        return r & mask;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int W  = (gi == 0) ? 4 : ((gi == 1) ? 1 : 64);
        localparam int CW = $clog2(W + 1);
        localparam logic [63:0] MASK = {64{1'b1}} >> (64 - W);

        logic          rdy_w, ov_w, zero_w, par_w;
        logic [W-1:0]  res_w, accv_w;
        logic [CW-1:0] pop_w;

        bitwise_logic_unit #(.WIDTH(W)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid_s[gi]),
            .in_ready   (rdy_w),
            .in_a       (a_s[gi][W-1:0]),
            .in_b       (b_s[gi][W-1:0]),
            .in_op      (op_s[gi]),
            .in_acc     (in_acc_s[gi]),
            .acc_clr    (acc_clr_s[gi]),
            .out_valid  (ov_w),
            .out_ready  (out_ready_s[gi]),
            .out_result (res_w),
            .out_zero   (zero_w),
            .out_parity (par_w),
            .out_popcnt (pop_w),
            .acc_value  (accv_w)
        );

        // Reference model: an in-order queue holding at most two operations.
        // The head becomes visible on the first edge after acceptance at which
        // it is at the front of the queue. The accumulator is read and updated
        // at that moment.
        ent_t        q[$];
        logic [63:0] m_acc = '0;

        always @(posedge clk or negedge rst_n) begin
            ent_t        e;
            logic [63:0] effa;
            logic        rdy;
            logic        clr;
            if (!rst_n) begin
                q.delete();
                m_acc = '0;
            end else begin
                rdy = (q.size() < 2) || out_ready_s[gi];
                clr = acc_clr_s[gi];
                if (q.size() > 0 && q[0].vis && out_ready_s[gi]) begin
                    void'(q.pop_front());
                end
                if (q.size() > 0 && !q[0].vis) begin
                    e     = q[0];
                    effa  = e.acc ? m_acc : e.a;
                    e.res = ref_op(e.op, effa, e.b, MASK);
                    e.vis = 1'b1;
                    q[0]  = e;
                    if (e.acc && !clr) m_acc = e.res;
                end
                if (clr) m_acc = '0;
                if (in_valid_s[gi] && rdy) begin
                    e.a   = a_s[gi] & MASK;
                    e.b   = b_s[gi] & MASK;
                    e.op  = op_s[gi];
                    e.acc = in_acc_s[gi];
                    e.res = '0;
                    e.vis = 1'b0;
                    q.push_back(e);
                end
            end
        end

        // Compare process: checks every DUT output against the model on each falling edge.
        always @(negedge clk) begin
            logic        exp_v;
            logic [63:0] er;
            exp_v = (q.size() > 0) && q[0].vis;
            chk($sformatf("w%0d_in_ready", W), 64'(rdy_w), 64'((q.size() < 2) || out_ready_s[gi]));
            chk($sformatf("w%0d_out_valid", W), 64'(ov_w), 64'(exp_v));
            chk($sformatf("w%0d_acc_value", W), 64'(accv_w), m_acc);
            if (exp_v) begin
                er = q[0].res;
                chk($sformatf("w%0d_result", W), 64'(res_w), er);
                chk($sformatf("w%0d_zero", W), 64'(zero_w), 64'(er == 64'd0));
                chk($sformatf("w%0d_parity", W), 64'(par_w), 64'(^er));
                chk($sformatf("w%0d_popcnt", W), 64'(pop_w), 64'($countones(er)));
            end
            if (!rst_n) begin
                chk($sformatf("w%0d_rst_result", W), 64'(res_w), 64'd0);
                chk($sformatf("w%0d_rst_zero", W), 64'(zero_w), 64'd1);
            end
        end
    end

    // Collect every result of the 4-bit instance that is handed downstream.
    always @(negedge clk) begin
        if (rst_n && g_inst[0].ov_w && out_ready_s[0]) coll_q.push_back(64'(g_inst[0].res_w));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        in_valid_s[0] = 1'b0;
        in_acc_s[0]   = 1'b0;
        acc_clr_s[0]  = 1'b0;
    endtask

    // Present one request to the 4-bit instance and hold it until it is accepted.
    task automatic send0(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic acc);
        logic r;
        bit   done;
        done = 0;
        in_valid_s[0] = 1'b1;
        op_s[0] = op;
        a_s[0] = a;
        b_s[0] = b;
        in_acc_s[0] = acc;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            r = g_inst[0].rdy_w;
            @(posedge clk);
            #1;
            if (r) done = 1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL send_accept: request op %0d not accepted within 50 cycles", op);
        end
        in_valid_s[0] = 1'b0;
    endtask

    logic [63:0] lit [8];
    int          acc_cnt;

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_valid_s[i] = 0; in_acc_s[i] = 0; acc_clr_s[i] = 0; out_ready_s[i] = 1;
            op_s[i] = 0; a_s[i] = 0; b_s[i] = 0;
        end
        lit[0] = 64'h8; lit[1] = 64'hE; lit[2] = 64'h6; lit[3] = 64'h3;
        lit[4] = 64'h7; lit[5] = 64'h1; lit[6] = 64'h9; lit[7] = 64'hA;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_zero", 64'(g_inst[0].zero_w), 64'd1);
        rst_n = 1'b1;
        tick();

        // All eight opcodes with a=1100, b=1010, back to back, two edges of latency.
        fork
            begin
                for (int k = 0; k < 8; k++) send0(3'(k), 64'hC, 64'hA, 1'b0);
                idle0();
            end
            begin
                @(posedge clk);
                @(posedge clk);
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    chk($sformatf("op%0d_valid", k), 64'(g_inst[0].ov_w), 64'd1);
                    chk($sformatf("op%0d_result", k), 64'(g_inst[0].res_w), lit[k]);
                    @(posedge clk);
                end
            end
        join
        repeat (2) tick();

        // Accumulator chaining: clear, PASS_B 0101, then XOR 1111, both in accumulator mode.
        acc_clr_s[0] = 1'b1;
        tick();
        acc_clr_s[0] = 1'b0;
        chk("chain_acc_cleared", 64'(g_inst[0].accv_w), 64'd0);
        coll_q.delete();
        send0(3'd7, 64'h0, 64'h5, 1'b1);
        send0(3'd2, 64'h0, 64'hF, 1'b1);
        idle0();
        tick();
        chk("chain_result", 64'(g_inst[0].res_w), 64'hA);
        chk("chain_acc", 64'(g_inst[0].accv_w), 64'hA);
        chk("chain_popcnt", 64'(g_inst[0].pop_w), 64'd2);
        chk("chain_parity", 64'(g_inst[0].par_w), 64'd0);
        tick();
        chk("chain_count", 64'(coll_q.size()), 64'd2);
        if (coll_q.size() == 2) begin
            chk("chain_first", coll_q[0], 64'h5);
            chk("chain_second", coll_q[1], 64'hA);
        end

        // Clear coincident with the transfer of an accumulator-mode OR.
        send0(3'd7, 64'h0, 64'h3, 1'b1);
        idle0();
        repeat (2) tick();
        chk("collide_acc_pre", 64'(g_inst[0].accv_w), 64'h3);
        send0(3'd1, 64'h0, 64'h4, 1'b1);
        acc_clr_s[0] = 1'b1;
        tick();
        acc_clr_s[0] = 1'b0;
        chk("collide_result", 64'(g_inst[0].res_w), 64'h7);
        chk("collide_acc", 64'(g_inst[0].accv_w), 64'h0);
        repeat (2) tick();

        // Backpressure: four requests with the output stalled.
        coll_q.delete();
        out_ready_s[0] = 1'b0;
        acc_cnt = 0;
        fork
            begin
                for (int k = 1; k <= 4; k++) begin
                    send0(3'd7, 64'h0, 64'(k), 1'b0);
                    acc_cnt++;
                end
                idle0();
            end
            begin
                repeat (4) tick();
                chk("bp_accepted", 64'(acc_cnt), 64'd2);
                chk("bp_in_ready", 64'(g_inst[0].rdy_w), 64'd0);
                out_ready_s[0] = 1'b1;
            end
        join
        repeat (5) tick();
        chk("bp_count", 64'(coll_q.size()), 64'd4);
        if (coll_q.size() == 4) begin
            for (int k = 0; k < 4; k++) chk($sformatf("bp_order%0d", k), coll_q[k], 64'(k + 1));
        end

        // Mid-operation reset with both stages full and a nonzero accumulator.
        send0(3'd7, 64'h0, 64'h9, 1'b1);
        idle0();
        repeat (2) tick();
        out_ready_s[0] = 1'b0;
        send0(3'd7, 64'h0, 64'h3, 1'b0);
        send0(3'd7, 64'h0, 64'h4, 1'b0);
        idle0();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(g_inst[0].ov_w), 64'd0);
        chk("rst_acc", 64'(g_inst[0].accv_w), 64'd0);
        chk("rst_zero", 64'(g_inst[0].zero_w), 64'd1);
        chk("rst_in_ready", 64'(g_inst[0].rdy_w), 64'd1);
        out_ready_s[0] = 1'b1;
        tick();
        rst_n = 1'b1;
        coll_q.delete();
        send0(3'd7, 64'h0, 64'h6, 1'b0);
        idle0();
        repeat (6) tick();
        chk("post_rst_count", 64'(coll_q.size()), 64'd1);
        if (coll_q.size() == 1) chk("post_rst_value", coll_q[0], 64'h6);

        // Randomized traffic on all three widths.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                in_valid_s[i]  = ($urandom_range(3) != 0);
                op_s[i]        = 3'($urandom_range(7));
                a_s[i]         = {$urandom, $urandom};
                b_s[i]         = {$urandom, $urandom};
                in_acc_s[i]    = 1'($urandom_range(1));
                acc_clr_s[i]   = ($urandom_range(15) == 0);
                out_ready_s[i] = ($urandom_range(3) != 0);
            end
            tick();
        end

        // Drain, then an all-ones PASS_B on every width.
        for (int i = 0; i < 3; i++) begin
            in_valid_s[i] = 0; acc_clr_s[i] = 0; in_acc_s[i] = 0; out_ready_s[i] = 1;
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            in_valid_s[i] = 1; op_s[i] = 3'd7; b_s[i] = {64{1'b1}};
        end
        tick();
        for (int i = 0; i < 3; i++) in_valid_s[i] = 0;
        tick();
        chk("ones_popcnt_w4", 64'(g_inst[0].pop_w), 64'd4);
        chk("ones_popcnt_w1", 64'(g_inst[1].pop_w), 64'd1);
        chk("ones_popcnt_w64", 64'(g_inst[2].pop_w), 64'd64);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
